// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states, result codes
// and the per-bit sanity check applied to upstream comparator results.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] CMP_LT   = 2'd0;
    localparam logic [1:0] CMP_GT   = 2'd1;
    localparam logic [1:0] CMP_EQ   = 2'd2;
    localparam logic [1:0] CMP_NONE = 2'd3;

    // A well-formed bit result has exactly one of lt/gt/eq set.
    function automatic logic bit_malformed(input logic lt, input logic gt, input logic eq);
        return (lt & gt) | (eq != ~(lt | gt));
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator.sv
// Folds MSB-first per-bit lt/gt/eq results into a word-level magnitude result;
// the first decisive bit wins, malformed bits raise a sticky error.
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_lt,
    input  logic             bit_gt,
    input  logic             bit_eq,
    output logic             busy,
    output logic             done,
    output logic             result_lt,
    output logic             result_gt,
    output logic             result_eq,
    output logic             err,
    output logic [CNT_W-1:0] bit_count
);

    state_t     state;
    state_t     state_next;
    logic [1:0] result_code;
    logic       decided;
    logic       err_q;
    logic [CNT_W-1:0] count_q;

    logic accept;
    logic last_bit;
    logic malformed;
    logic bit_decides;

    assign malformed   = bit_malformed(bit_lt, bit_gt, bit_eq);
    assign accept      = (state == RUN) && bit_valid && !start;
    assign last_bit    = accept && (count_q == CNT_W'(WIDTH - 1));
    assign bit_decides = !decided && !malformed && (bit_gt || bit_lt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                if (start) begin
                    state_next = RUN;
                end else if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        result_lt = (result_code == CMP_LT);
        result_gt = (result_code == CMP_GT);
        result_eq = (result_code == CMP_EQ);
        err       = err_q;
        bit_count = count_q;
    end

    // The counter holds at WIDTH-1 on the final bit so it never wraps in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_code <= CMP_NONE;
            decided     <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else if (start) begin
            result_code <= CMP_NONE;
            decided     <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else if (accept) begin
            if (malformed) begin
                err_q <= 1'b1;
            end
            if (bit_decides) begin
                result_code <= bit_gt ? CMP_GT : CMP_LT;
                decided     <= 1'b1;
            end else if (last_bit && !decided) begin
                result_code <= CMP_EQ;
            end
            if (!last_bit) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench: per-bit results come from an inline 1-bit comparator model,
// expected word results are queued at stimulus time and popped at done.
module tb_serial_magnitude_comparator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       bit_valid;
    logic       a_bit;
    logic       b_bit;
    logic       force_bad;
    logic       bit_lt;
    logic       bit_gt;
    logic       bit_eq;
    logic       busy;
    logic       done;
    logic       result_lt;
    logic       result_gt;
    logic       result_eq;
    logic       err;
    logic [2:0] bit_count;

    typedef struct {
        logic lt;
        logic gt;
        logic eq;
        logic err;
        int   latency;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_seen = 0;
    int   done_before;

    assign bit_lt = force_bad ? 1'b1 : (~a_bit & b_bit);
    assign bit_gt = force_bad ? 1'b1 : (a_bit & ~b_bit);
    assign bit_eq = ~(a_bit ^ b_bit);

    serial_magnitude_comparator #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .bit_lt    (bit_lt),
        .bit_gt    (bit_gt),
        .bit_eq    (bit_eq),
        .busy      (busy),
        .done      (done),
        .result_lt (result_lt),
        .result_gt (result_gt),
        .result_eq (result_eq),
        .err       (err),
        .bit_count (bit_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_seen++;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input int bad_idx, input bit stall);
        exp_t e;
        e.lt = 1'b0; e.gt = 1'b0; e.eq = 1'b1;
        e.err = (bad_idx >= 0 && bad_idx < 8);
        e.latency = stall ? 17 : 9;
        for (int i = 0; i < 8; i++) begin
            if (i != bad_idx && a[7-i] != b[7-i]) begin
                e.gt = a[7-i];
                e.lt = b[7-i];
                e.eq = 1'b0;
                break;
            end
        end
        return e;
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        bit_valid = 1'b0;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] a, input logic [7:0] b, input int n,
                             input bit stall, input int bad_idx);
        for (int i = 0; i < n; i++) begin
            if (stall) begin
                bit_valid = 1'b0;
                @(posedge clk);
                cyc++;
                @(negedge clk);
            end
            a_bit = a[7-i];
            b_bit = b[7-i];
            force_bad = (i == bad_idx);
            bit_valid = 1'b1;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            bit_valid = 1'b0;
            force_bad = 1'b0;
        end
    endtask

    task automatic check_result(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty observed=done expected=entry", name);
        end else begin
            e = sb.pop_front();
            chk({name, "_done"}, done, 1);
            chk({name, "_latency"}, cyc, e.latency);
            chk({name, "_lt"}, result_lt, e.lt);
            chk({name, "_gt"}, result_gt, e.gt);
            chk({name, "_eq"}, result_eq, e.eq);
            chk({name, "_err"}, err, e.err);
            chk({name, "_busy"}, busy, 0);
            chk({name, "_count"}, bit_count, 7);
            @(negedge clk);
            chk({name, "_done_pulse"}, done, 0);
            chk({name, "_held"}, {result_lt, result_gt, result_eq}, {e.lt, e.gt, e.eq});
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0;
        a_bit = 1'b0; b_bit = 1'b0; force_bad = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, result_lt, result_gt, result_eq, err, bit_count},
            9'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {busy, done}, 2'b00);

        // decision at bit 2, later bits ignored
        sb.push_back(model(8'hA5, 8'hA3, -1, 1'b0));
        do_start();
        chk("start_busy", busy, 1);
        chk("start_count", bit_count, 0);
        send_bits(8'hA5, 8'hA3, 8, 1'b0, -1);
        check_result("a5_a3");

        sb.push_back(model(8'h3C, 8'h3C, -1, 1'b0));
        do_start();
        send_bits(8'h3C, 8'h3C, 8, 1'b0, -1);
        check_result("equal");

        sb.push_back(model(8'h00, 8'h80, -1, 1'b1));
        do_start();
        send_bits(8'h00, 8'h80, 3, 1'b1, -1);
        chk("stall_count", bit_count, 3);
        send_bits(8'h00, 8'h80, 5, 1'b1, -1);
        check_result("stall_lt");

        sb.push_back(model(8'h5A, 8'h5A, 2, 1'b0));
        do_start();
        send_bits(8'h5A, 8'h5A, 8, 1'b0, 2);
        check_result("malformed");

        // abort after 4 bits, then a clean word
        done_before = done_seen;
        do_start();
        send_bits(8'hFF, 8'h00, 4, 1'b0, -1);
        chk("abort_count", bit_count, 4);
        chk("abort_gt_pre", result_gt, 1);
        sb.push_back(model(8'h01, 8'h02, -1, 1'b0));
        do_start();
        chk("restart_count", bit_count, 0);
        chk("restart_cleared", {result_lt, result_gt, result_eq, busy}, 4'b0001);
        send_bits(8'h01, 8'h02, 8, 1'b0, -1);
        chk("abort_no_done", done_seen, done_before);
        check_result("restart_lt");

        // reset mid-word
        do_start();
        send_bits(8'hF0, 8'h10, 5, 1'b0, -1);
        chk("pre_rst_count", bit_count, 5);
        chk("pre_rst_gt", result_gt, 1);
        done_before = done_seen;
        rst = 1'b1;
        #1;
        chk("rst_async", {busy, done, result_lt, result_gt, result_eq, err, bit_count}, 9'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_idle", {busy, done}, 2'b00);
        chk("rst_no_done", done_seen, done_before);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
